// File: rtl/fetch_insn_queue_pkg.sv
// Types shared by fetch and the fetch-to-decode instruction queue.
// Width macros fall back to defaults when the surrounding build does not define them.
`ifndef M_WIDTH
`define M_WIDTH 64
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 16
`endif

package fetch_insn_queue_pkg;

    localparam int unsigned MWidth  = `M_WIDTH;
    localparam int unsigned LgPhtSz = `LG_PHT_SZ;

    typedef struct packed {
        logic [31:0]         insn;
        logic [MWidth-1:0]   pc;
        logic                pred;
        logic [LgPhtSz-1:0]  pht_idx;
        logic [MWidth-1:0]   pred_target;
`ifdef ENABLE_CYCLE_ACCOUNTING
        logic [63:0]         fetch_cycle;
`endif
    } fetch_entry_t;

endpackage

// File: rtl/fetch_insn_queue_fifo_ptr_ctrl.sv
// Head/tail pointer and occupancy control for the fetch instruction queue.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_insn_queue_fifo_ptr_ctrl #(
    parameter int unsigned LG_DEPTH = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    output logic                enq,
    output logic                deq,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic [LG_DEPTH-1:0] head_idx,
    output logic [LG_DEPTH-1:0] tail_idx,
    output logic [LG_DEPTH:0]   occupancy
);

    localparam int unsigned       Depth   = 1 << LG_DEPTH;
    localparam logic [LG_DEPTH:0] One     = (LG_DEPTH+1)'(1);
    localparam logic [LG_DEPTH:0] AfLevel = (LG_DEPTH+1)'(Depth - 1);

    logic [LG_DEPTH:0] head_q, tail_q, occ_q;

    always_comb begin
        empty = (head_q == tail_q);
        full  = (head_q[LG_DEPTH-1:0] == tail_q[LG_DEPTH-1:0]) &&
                (head_q[LG_DEPTH] != tail_q[LG_DEPTH]);
        // Flush wins over both handshakes in the same cycle.
        enq   = push && !full && !flush;
        deq   = pop && !empty && !flush;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else if (flush) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            if (enq) tail_q <= tail_q + One;
            if (deq) head_q <= head_q + One;
            case ({enq, deq})
                2'b10:   occ_q <= occ_q + One;
                2'b01:   occ_q <= occ_q - One;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head_idx    = head_q[LG_DEPTH-1:0];
    assign tail_idx    = tail_q[LG_DEPTH-1:0];
    assign occupancy   = occ_q;
    assign almost_full = (occ_q >= AfLevel);

endmodule

// File: rtl/fetch_insn_queue.sv
// Instruction FIFO between fetch and decode; head entry feeds the decoder directly.
// in_ready depends only on registered state, so a dequeue never frees a slot in the same cycle.
module fetch_insn_queue
    import fetch_insn_queue_pkg::*;
#(
    parameter int unsigned LG_DEPTH = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_insn,
    input  logic [MWidth-1:0]   in_pc,
    input  logic                in_pred,
    input  logic [LgPhtSz-1:0]  in_pht_idx,
    input  logic [MWidth-1:0]   in_pred_target,
`ifdef ENABLE_CYCLE_ACCOUNTING
    input  logic [63:0]         in_fetch_cycle,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_insn,
    output logic [MWidth-1:0]   out_pc,
    output logic                out_pred,
    output logic [LgPhtSz-1:0]  out_pht_idx,
    output logic [MWidth-1:0]   out_pred_target,
`ifdef ENABLE_CYCLE_ACCOUNTING
    output logic [63:0]         out_fetch_cycle,
`endif
    output logic [LG_DEPTH:0]   occupancy,
    output logic                almost_full
);

    localparam int unsigned Depth = 1 << LG_DEPTH;

    logic                enq, deq, full, empty;
    logic [LG_DEPTH-1:0] head_idx, tail_idx;
    fetch_entry_t        wr_entry, head_entry;
    fetch_entry_t        mem [Depth];

    fetch_insn_queue_fifo_ptr_ctrl #(
        .LG_DEPTH (LG_DEPTH)
    ) u_ptr_ctrl (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .push        (in_valid),
        .pop         (out_ready),
        .enq         (enq),
        .deq         (deq),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .head_idx    (head_idx),
        .tail_idx    (tail_idx),
        .occupancy   (occupancy)
    );

    always_comb begin
        wr_entry             = '0;
        wr_entry.insn        = in_insn;
        wr_entry.pc          = in_pc;
        wr_entry.pred        = in_pred;
        wr_entry.pht_idx     = in_pht_idx;
        wr_entry.pred_target = in_pred_target;
`ifdef ENABLE_CYCLE_ACCOUNTING
        wr_entry.fetch_cycle = in_fetch_cycle;
`endif
    end

    // Storage is intentionally not reset; out_* is don't-care while empty.
    always_ff @(posedge clk) begin
        if (enq) mem[tail_idx] <= wr_entry;
    end

    assign head_entry      = mem[head_idx];
    assign in_ready        = !full;
    assign out_valid       = !empty;
    assign out_insn        = head_entry.insn;
    assign out_pc          = head_entry.pc;
    assign out_pred        = head_entry.pred;
    assign out_pht_idx     = head_entry.pht_idx;
    assign out_pred_target = head_entry.pred_target;
`ifdef ENABLE_CYCLE_ACCOUNTING
    assign out_fetch_cycle = head_entry.fetch_cycle;
`endif

    logic unused_deq;
    assign unused_deq = deq;

endmodule

// File: tb/tb_fetch_insn_queue.sv
// Randomized bench for fetch_insn_queue against a queue-based reference model.
module tb_fetch_insn_queue;
    import fetch_insn_queue_pkg::*;

    localparam int unsigned LgDepth = 3;
    localparam int unsigned Depth   = 1 << LgDepth;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_insn;
    logic [MWidth-1:0]   in_pc;
    logic                in_pred;
    logic [LgPhtSz-1:0]  in_pht_idx;
    logic [MWidth-1:0]   in_pred_target;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_insn;
    logic [MWidth-1:0]   out_pc;
    logic                out_pred;
    logic [LgPhtSz-1:0]  out_pht_idx;
    logic [MWidth-1:0]   out_pred_target;
    logic [LgDepth:0]    occupancy;
    logic                almost_full;
`ifdef ENABLE_CYCLE_ACCOUNTING
    logic [63:0]         in_fetch_cycle;
    logic [63:0]         out_fetch_cycle;
`endif

    int total = 0;
    int bad   = 0;
    fetch_entry_t model_q[$];

    always #5 clk = ~clk;

    fetch_insn_queue #(
        .LG_DEPTH (LgDepth)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_insn         (in_insn),
        .in_pc           (in_pc),
        .in_pred         (in_pred),
        .in_pht_idx      (in_pht_idx),
        .in_pred_target  (in_pred_target),
`ifdef ENABLE_CYCLE_ACCOUNTING
        .in_fetch_cycle  (in_fetch_cycle),
`endif
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_insn        (out_insn),
        .out_pc          (out_pc),
        .out_pred        (out_pred),
        .out_pht_idx     (out_pht_idx),
        .out_pred_target (out_pred_target),
`ifdef ENABLE_CYCLE_ACCOUNTING
        .out_fetch_cycle (out_fetch_cycle),
`endif
        .occupancy       (occupancy),
        .almost_full     (almost_full)
    );

    function automatic fetch_entry_t in_entry();
        fetch_entry_t e;
        e             = '0;
        e.insn        = in_insn;
        e.pc          = in_pc;
        e.pred        = in_pred;
        e.pht_idx     = in_pht_idx;
        e.pred_target = in_pred_target;
`ifdef ENABLE_CYCLE_ACCOUNTING
        e.fetch_cycle = in_fetch_cycle;
`endif
        return e;
    endfunction

    function automatic fetch_entry_t out_entry();
        fetch_entry_t e;
        e             = '0;
        e.insn        = out_insn;
        e.pc          = out_pc;
        e.pred        = out_pred;
        e.pht_idx     = out_pht_idx;
        e.pred_target = out_pred_target;
`ifdef ENABLE_CYCLE_ACCOUNTING
        e.fetch_cycle = out_fetch_cycle;
`endif
        return e;
    endfunction

    task automatic rand_in();
        in_insn        = $urandom;
        in_pc          = MWidth'({$urandom, $urandom});
        in_pred        = 1'($urandom);
        in_pht_idx     = LgPhtSz'($urandom);
        in_pred_target = MWidth'({$urandom, $urandom});
`ifdef ENABLE_CYCLE_ACCOUNTING
        in_fetch_cycle = {$urandom, $urandom};
`endif
    endtask

    // Advance one clock; the model applies the FIFO rules to the inputs held across the edge.
    task automatic cycle();
        int sz;
        bit e, d;
        fetch_entry_t ent;
        sz  = model_q.size();
        e   = in_valid && (sz < Depth) && !flush;
        d   = out_ready && (sz > 0) && !flush;
        ent = in_entry();
        @(posedge clk);
        if (flush) begin
            model_q.delete();
        end else begin
            if (d) void'(model_q.pop_front());
            if (e) model_q.push_back(ent);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total += 4;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        if (occupancy !== '0) begin
            bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy);
        end
        if (almost_full !== 1'b0) begin
            bad++; $display("FAIL reset_almost_full got=%b want=0", almost_full);
        end
    endtask

    task automatic test_single();
        rand_in();
        in_insn  = 32'h0000_0013;
        in_pc    = MWidth'(32'h1000);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        total += 4;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL single_valid got=%b want=1", out_valid);
        end
        if (out_insn !== 32'h13) begin
            bad++; $display("FAIL single_insn got=%h want=00000013", out_insn);
        end
        if (out_pc !== MWidth'(32'h1000)) begin
            bad++; $display("FAIL single_pc got=%h want=1000", out_pc);
        end
        if (occupancy !== 1) begin
            bad++; $display("FAIL single_occ1 got=%0d want=1", occupancy);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        total += 2;
        if (occupancy !== 0) begin
            bad++; $display("FAIL single_occ0 got=%0d want=0", occupancy);
        end
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL single_empty got=%b want=0", out_valid);
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 1; i <= Depth; i++) begin
            rand_in();
            in_valid = 1'b1;
            cycle();
            total += 3;
            if (occupancy !== (LgDepth+1)'(i)) begin
                bad++; $display("FAIL fill_occ got=%0d want=%0d", occupancy, i);
            end
            if (almost_full !== (i >= Depth - 1)) begin
                bad++; $display("FAIL fill_almost_full occ=%0d got=%b want=%b",
                                i, almost_full, (i >= Depth - 1));
            end
            if (in_ready !== (i < Depth)) begin
                bad++; $display("FAIL fill_in_ready occ=%0d got=%b want=%b",
                                i, in_ready, (i < Depth));
            end
        end
        // Full: a same-cycle dequeue must not let this entry in.
        rand_in();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total += 3;
        if (occupancy !== (LgDepth+1)'(Depth - 1)) begin
            bad++; $display("FAIL full_enq_deq_occ got=%0d want=%0d", occupancy, Depth - 1);
        end
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL full_enq_deq_ready got=%b want=1", in_ready);
        end
        if (out_entry() !== model_q[0]) begin
            bad++; $display("FAIL full_enq_deq_head got=%h want=%h", out_entry(), model_q[0]);
        end
        out_ready = 1'b1;
        while (model_q.size() > 0) begin
            total++;
            if (out_entry() !== model_q[0]) begin
                bad++; $display("FAIL drain_head got=%h want=%h", out_entry(), model_q[0]);
            end
            cycle();
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL drain_empty got=%b want=0", out_valid);
        end
    endtask

    task automatic test_stream();
        int sent = 0;
        int budget = 600;
        rand_in();
        in_valid = 1'b1;
        while ((sent < 20 || model_q.size() > 0) && budget > 0) begin
            bit acc;
            total += 2;
            if (out_valid !== (model_q.size() > 0)) begin
                bad++; $display("FAIL stream_valid got=%b want=%b", out_valid, model_q.size() > 0);
            end
            if (occupancy !== (LgDepth+1)'(model_q.size())) begin
                bad++; $display("FAIL stream_occ got=%0d want=%0d", occupancy, model_q.size());
            end
            if (model_q.size() > 0) begin
                total++;
                if (out_entry() !== model_q[0]) begin
                    bad++; $display("FAIL stream_head got=%h want=%h", out_entry(), model_q[0]);
                end
            end
            out_ready = 1'($urandom_range(0, 2) != 0);
            acc = in_valid && in_ready;
            cycle();
            budget--;
            if (acc) begin
                sent++;
                if (sent < 20) rand_in();
                in_valid = (sent < 20);
            end
        end
        idle_inputs();
        total++;
        if (budget == 0) begin
            bad++; $display("FAIL stream_timeout sent=%0d left=%0d want=all_drained",
                            sent, model_q.size());
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            rand_in();
            in_valid = 1'b1;
            cycle();
        end
        total++;
        if (occupancy !== 5) begin
            bad++; $display("FAIL flush_pre_occ got=%0d want=5", occupancy);
        end
        rand_in();
        in_insn  = 32'hdead_beef;
        in_valid = 1'b1;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        total += 3;
        if (occupancy !== 0) begin
            bad++; $display("FAIL flush_occ got=%0d want=0", occupancy);
        end
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_valid got=%b want=0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_ready got=%b want=1", in_ready);
        end
        rand_in();
        in_insn  = 32'h0000_0093;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        total += 2;
        if (out_insn !== 32'h93) begin
            bad++; $display("FAIL flush_next_insn got=%h want=00000093", out_insn);
        end
        if (occupancy !== 1) begin
            bad++; $display("FAIL flush_next_occ got=%0d want=1", occupancy);
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            rand_in();
            in_valid = 1'b1;
            cycle();
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_q.delete();
        total += 3;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL areset_valid got=%b want=0", out_valid);
        end
        if (occupancy !== 0) begin
            bad++; $display("FAIL areset_occ got=%0d want=0", occupancy);
        end
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL areset_ready got=%b want=1", in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rand_in();
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        total += 2;
        if (occupancy !== 1) begin
            bad++; $display("FAIL areset_next_occ got=%0d want=1", occupancy);
        end
        if (out_entry() !== model_q[0]) begin
            bad++; $display("FAIL areset_next_head got=%h want=%h", out_entry(), model_q[0]);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        rand_in();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
